// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor: operands and borrow-in
// toward the subtractor, status and result back to the requester.
interface serial_subtractor_if #(
    parameter int N = 5
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         Bout;
    logic         ovf;

    modport master (
        output start, a, b, Bin,
        input  busy, done, diff, Bout, ovf
    );

    modport slave (
        input  start, a, b, Bin,
        output busy, done, diff, Bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor computing a - b - Bin LSB first, one full-subtractor
// step per clock. Optional signed overflow flag guarded by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int N = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    a_sr_q, a_sr_d;
    logic [N-1:0]    b_sr_q, b_sr_d;
    logic            br_q, br_d;
    logic [N-1:0]    res_q, res_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            d_bit_s;
    logic            br_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    // Single full-subtractor cell operating on the current LSBs
    always_comb begin
        d_bit_s  = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
        br_nxt_s = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    br_d    = bus.Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d = {1'b0, a_sr_q[N-1:1]};
                b_sr_d = {1'b0, b_sr_q[N-1:1]};
                br_d   = br_nxt_s;
                res_d  = {d_bit_s, res_q[N-1:1]};
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {d_bit_s, res_q[N-1:1]};
                    bout_d  = br_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
                    // br_q here is the borrow into the MSB
                    ovf_d   = br_q ^ br_nxt_s;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, shift registers and committed results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
    assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`else
    assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes arithmetic-model results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic bin, input int acc);
        exp_t e;
        int   r, sa, sb, rs;
        r      = int'(a) - int'(b) - int'(bin);
        e.diff = N'(r);
        e.bout = (r < 0);
        sa     = a[N-1] ? int'(a) - (1 << N) : int'(a);
        sb     = b[N-1] ? int'(b) - (1 << N) : int'(b);
        rs     = sa - sb - int'(bin);
`ifdef SERIAL_SUB_OVF_EN
        e.ovf  = (rs < -(1 << (N - 1))) || (rs > (1 << (N - 1)) - 1);
`else
        e.ovf  = 1'b0;
`endif
        e.acc  = acc;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sbq.pop_front();
                check("diff", int'(bus.diff), int'(mon_e.diff));
                check("Bout", int'(bus.Bout), int'(mon_e.bout));
                check("ovf", int'(bus.ovf), int'(mon_e.ovf));
                check("latency", cyc - mon_e.acc, N);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE negedge
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic bin, input bit hold);
        bus.a     = a;
        bus.b     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        @(negedge clk);
        sbq.push_back(model(a, b, bin, cyc));
        check("busy_run", int'(bus.busy), 1);
        if (!hold) bus.start = 1'b0;
        for (int i = 1; i < N; i++) begin
            bus.a   = N'($urandom);
            bus.b   = N'($urandom);
            bus.Bin = 1'($urandom);
            @(negedge clk);
            check("busy_run", int'(bus.busy), 1);
        end
        @(negedge clk);
        check("busy_in_done", int'(bus.busy), 0);
        check("done_pulse", int'(bus.done), 1);
    endtask

    task automatic gap(input int n);
        bus.start = 1'b0;
        if (n > 0) begin
            @(negedge clk);
            check("done_one_cycle", int'(bus.done), 0);
            repeat (n - 1) @(negedge clk);
        end
    endtask

    initial begin
        bit hold;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.Bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_diff", int'(bus.diff), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        issue(5'b00111, 5'b01011, 1'b0, 1'b0);
        gap(2);
        issue(5'b01111, 5'b11011, 1'b0, 1'b0);
        issue(5'b11011, 5'b00111, 1'b1, 1'b0);
        gap(1);
        issue(5'b00000, 5'b00000, 1'b1, 1'b0);
        gap(2);
        issue(5'b00111, 5'b01011, 1'b0, 1'b1);
        issue(5'b01111, 5'b11011, 1'b0, 1'b0);
        gap(1);

        // Abort an operation in its third RUN cycle with an async reset
        bus.a     = 5'b00111;
        bus.b     = 5'b01011;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_diff", int'(bus.diff), 0);
        check("abort_Bout", int'(bus.Bout), 0);
        check("abort_ovf", int'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_busy", int'(bus.busy), 0);
        issue(5'b00111, 5'b01011, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            hold = 1'($urandom);
            issue(N'($urandom), N'($urandom), 1'($urandom), hold);
            if (!hold) gap(int'($urandom_range(0, 2)));
        end
        issue(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
        gap(3);
        check("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
